// File: rtl/detector_modulo_pkg.sv
// Shared constants and FSM encoding for the modulo-counter modulus detector.
package detector_modulo_pkg;
    localparam int MOD_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;
endpackage

// File: rtl/detector_modulo.sv
// Recovers the modulus N of an observed modulo-N counter, confirming it over
// two consecutive wraps and flagging illegal steps and modulus changes.
module detector_modulo
    import detector_modulo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [MOD_W-1:0] q_in,
    output logic [MOD_W-1:0] n_out,
    output logic             locked,
    output logic             wrap,
    output logic             change,
    output logic             err
);
    state_t           state, state_nx;
    logic [MOD_W-1:0] q_prev, n_nx;
    logic             locked_nx, wrap_nx, change_nx, err_nx;

    // Increment kept one bit wider so q_prev=255 never aliases onto 0.
    logic [MOD_W:0]   q_inc;
    logic             is_step, zero_ok, n_match, n_above;

    assign q_inc   = {1'b0, q_prev} + 1'b1;
    assign is_step = ({1'b0, q_in} == q_inc);
    assign zero_ok = (q_in == '0) && !q_inc[MOD_W];
    assign n_match = (q_inc == {1'b0, n_out});
    assign n_above = (q_inc <  {1'b0, n_out});

    always_comb begin
        state_nx  = state;
        n_nx      = n_out;
        locked_nx = locked;
        wrap_nx   = 1'b0;
        change_nx = 1'b0;
        err_nx    = 1'b0;
        if (en) begin
            case (state)
                IDLE: state_nx = SYNC;
                SYNC: begin
                    if (zero_ok) begin
                        wrap_nx  = 1'b1;
                        state_nx = MEASURE;
                    end else if (!is_step) begin
                        err_nx = 1'b1;
                    end
                end
                MEASURE: begin
                    if (zero_ok) begin
                        wrap_nx   = 1'b1;
                        n_nx      = q_inc[MOD_W-1:0];
                        locked_nx = 1'b1;
                        state_nx  = LOCKED;
                    end else if (!is_step) begin
                        err_nx   = 1'b1;
                        state_nx = SYNC;
                    end
                end
                LOCKED: begin
                    if (n_match && zero_ok) begin
                        wrap_nx = 1'b1;
                    end else if (n_match && is_step) begin
                        // Counter ran past the locked modulus: it grew, re-measure.
                        change_nx = 1'b1;
                        locked_nx = 1'b0;
                        state_nx  = MEASURE;
                    end else if (n_above && is_step) begin
                        state_nx = LOCKED;
                    end else if (n_above && zero_ok) begin
                        wrap_nx   = 1'b1;
                        change_nx = 1'b1;
                        n_nx      = q_inc[MOD_W-1:0];
                    end else begin
                        err_nx    = 1'b1;
                        locked_nx = 1'b0;
                        state_nx  = SYNC;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q_prev <= '0;
            n_out  <= '0;
            locked <= 1'b0;
            wrap   <= 1'b0;
            change <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            if (en) q_prev <= q_in;
            n_out  <= n_nx;
            locked <= locked_nx;
            wrap   <= wrap_nx;
            change <= change_nx;
            err    <= err_nx;
        end
    end
endmodule

// File: tb/tb_detector_modulo.sv
// Self-checking bench: directed scenarios plus randomized counter traffic,
// compared against a wrap-counting reference model.
module tb_detector_modulo;
    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] q_in;
    logic [7:0] n_out;
    logic       locked, wrap, change, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: tracks how many consecutive legal wraps were seen.
    bit m_have, m_locked, m_wrap, m_change, m_err;
    int m_prev, m_wraps, m_n;

    detector_modulo dut (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in),
        .n_out(n_out), .locked(locked), .wrap(wrap), .change(change), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input int q);
        m_wrap = 0; m_change = 0; m_err = 0;
        if (r) begin
            m_have = 0; m_prev = 0; m_wraps = 0; m_n = 0; m_locked = 0;
        end else if (e) begin
            if (!m_have) begin
                m_have = 1;
            end else if (!((q == m_prev + 1) || (q == 0 && m_prev != 255))) begin
                m_err = 1; m_locked = 0; m_wraps = 0;
            end else if (q == 0) begin
                m_wrap = 1;
                m_wraps++;
                if (m_locked) begin
                    if (m_prev + 1 < m_n) begin
                        m_change = 1; m_n = m_prev + 1;
                    end
                end else if (m_wraps >= 2) begin
                    m_locked = 1; m_n = m_prev + 1;
                end
            end else if (m_locked && q == m_n) begin
                m_change = 1; m_locked = 0; m_wraps = 1;
            end
            m_prev = q;
        end
    endtask

    task automatic step(input bit r, input bit e, input int q);
        rst = r; en = e; q_in = q[7:0];
        @(posedge clk);
        model(r, e, q);
        #1;
        check("n_out",  n_out,  m_n);
        check("locked", locked, m_locked);
        check("wrap",   wrap,   m_wrap);
        check("change", change, m_change);
        check("err",    err,    m_err);
        check("wrap_err_excl", wrap & err, 0);
    endtask

    task automatic count(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) step(0, 1, i);
    endtask

    int gq, gn;

    initial begin
        rst = 1; en = 0; q_in = 0;
        model(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 3);
        check("reset_n_out", n_out, 0);
        check("reset_locked", locked, 0);

        // N=5 lock, then growth to 20, then early wrap to 8
        count(0, 4); count(0, 4); step(0, 1, 0);
        check("n5_lock", locked, 1);
        check("n5_value", n_out, 5);
        count(1, 4); step(0, 1, 5);
        check("grow_change", change, 1);
        check("grow_unlock", locked, 0);
        count(6, 19); step(0, 1, 0);
        check("n20_value", n_out, 20);
        check("n20_lock", locked, 1);
        count(1, 7); step(0, 1, 0);
        check("early_wrap", wrap & change, 1);
        check("n8_value", n_out, 8);
        check("n8_lock", locked, 1);

        // Illegal step while locked, then relock at 5
        step(1, 0, 0);
        count(0, 4); count(0, 4); step(0, 1, 0);
        count(1, 3); step(0, 1, 9);
        check("jump_err", err, 1);
        check("jump_unlock", locked, 0);
        count(10, 12); step(0, 1, 0); count(1, 4); step(0, 1, 0);
        check("relock5", n_out, 5);

        // Modulus 1 with en toggling
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, i % 2 == 0, 0);
        check("n1_value", n_out, 1);
        check("n1_lock", locked, 1);

        // Reset mid-lock, then 255 -> 0 is illegal
        step(1, 1, 0);
        check("rst_locked", locked, 0);
        count(250, 255); step(0, 1, 0);
        check("wrap256_err", err, 1);
        count(1, 2);

        // Randomized traffic
        gq = 0; gn = 7;
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 1) begin
                step(1, $urandom_range(0, 1), gq);
            end else if (r < 15) begin
                step(0, 0, $urandom_range(0, 255));
            end else begin
                if (r < 18)      gq = $urandom_range(0, 255);
                else if (r < 21) gq = 0;
                else if (r < 23) begin
                    gn = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 256)
                                                     : $urandom_range(1, 30);
                    gq = (gq + 1) % gn;
                end else gq = (gq + 1) % gn;
                step(0, 1, gq);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
